// File: rtl/dot8_result_gather.sv
`default_nettype none
// ============================================================================
// Module   : dot8_result_gather
// Purpose  : Reassembles lane-serialized dot8 result chunks (sop..eop) into a
//            full-warp writeback and flags chunk framing errors.
// Revision : 1.0
// ============================================================================
module dot8_result_gather #(
  parameter int NUM_LANES     = 1,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int UUID_WIDTH    = 44,
  parameter int NW_WIDTH      = 2,
  parameter int PC_BITS       = 30,
  parameter int NUM_REGS_BITS = 5,
  localparam int PID_WIDTH    = ((NUM_THREADS / NUM_LANES) > 1) ?
                                $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [PC_BITS-1:0]          in_PC,
  input  logic                        in_wb,
  input  logic [NUM_REGS_BITS-1:0]    in_rd,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [PC_BITS-1:0]          out_PC,
  output logic                        out_wb,
  output logic [NUM_REGS_BITS-1:0]    out_rd,

  output logic                        err_proto
);

  localparam int c_NUM_PIDS   = NUM_THREADS / NUM_LANES;
  localparam int c_CHUNK_BITS = NUM_LANES * XLEN;
  localparam logic [PID_WIDTH:0] c_PID_LIMIT = (PID_WIDTH + 1)'(c_NUM_PIDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_out_valid;
  logic [NUM_THREADS*XLEN-1:0]   r_data;
  logic [NUM_THREADS-1:0]        r_tmask;
  logic [UUID_WIDTH-1:0]         r_uuid;
  logic [NW_WIDTH-1:0]           r_wid;
  logic [PC_BITS-1:0]            r_pc;
  logic                          r_wb;
  logic [NUM_REGS_BITS-1:0]      r_rd;
  logic                          r_err;

  logic                          w_in_ready;
  logic                          w_accept;
  logic                          w_fire;
  logic                          w_sop_start;
  logic                          w_chunk_wr;
  logic                          w_meta_mismatch;
  logic [NUM_THREADS*XLEN-1:0]   w_data_next;
  logic [NUM_THREADS-1:0]        w_tmask_next;

  // The output registers double as the assembly buffer; FULL may take a new
  // sop only when the held result leaves on the same edge.
  assign w_in_ready  = reset & ((r_state != S_FULL) | out_ready);
  assign w_accept    = in_valid & w_in_ready;
  assign w_fire      = r_out_valid & out_ready;
  assign w_sop_start = w_accept & in_sop;
  assign w_chunk_wr  = w_sop_start | (w_accept & ~in_sop & (r_state == S_COLLECT));

  assign w_meta_mismatch = (in_wid != r_wid) | (in_uuid != r_uuid);

  // A sop starts from a clean buffer so stale slots never leak into a short packet.
  always_comb begin
    w_data_next  = w_sop_start ? '0 : r_data;
    w_tmask_next = w_sop_start ? '0 : r_tmask;
    for (int p = 0; p < c_NUM_PIDS; p++) begin
      if (in_pid == PID_WIDTH'(p)) begin
        w_data_next[p*c_CHUNK_BITS +: c_CHUNK_BITS] = in_data;
        w_tmask_next[p*NUM_LANES +: NUM_LANES]      = in_tmask;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_tmask     <= '0;
      r_uuid      <= '0;
      r_wid       <= '0;
      r_pc        <= '0;
      r_wb        <= 1'b0;
      r_rd        <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_chunk_wr) begin
        r_data  <= w_data_next;
        r_tmask <= w_tmask_next;
      end
      if (w_sop_start) begin
        r_uuid <= in_uuid;
        r_wid  <= in_wid;
        r_pc   <= in_PC;
        r_wb   <= in_wb;
        r_rd   <= in_rd;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_sop) begin
              r_state     <= in_eop ? S_FULL : S_COLLECT;
              r_out_valid <= in_eop;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            if (in_sop) begin
              r_err       <= 1'b1;
              r_state     <= in_eop ? S_FULL : S_COLLECT;
              r_out_valid <= in_eop;
            end else begin
              if (w_meta_mismatch) begin
                r_err <= 1'b1;
              end
              if (in_eop) begin
                r_state     <= S_FULL;
                r_out_valid <= 1'b1;
              end
            end
          end
        end

        S_FULL: begin
          if (w_fire) begin
            if (w_accept && in_sop) begin
              r_state     <= in_eop ? S_FULL : S_COLLECT;
              r_out_valid <= in_eop;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              if (w_accept) begin
                r_err <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign out_tmask = r_tmask;
  assign out_uuid  = r_uuid;
  assign out_wid   = r_wid;
  assign out_PC    = r_pc;
  assign out_wb    = r_wb;
  assign out_rd    = r_rd;
  assign err_proto = r_err;

  // Upstream never produces a pid beyond the warp; catch it in simulation.
  a_pid_range : assert property (@(posedge clk) disable iff (!reset)
                                 w_accept |-> ({1'b0, in_pid} < c_PID_LIMIT));

endmodule
`default_nettype wire

// File: tb/tb_dot8_result_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot8_result_gather
// Purpose  : Directed and randomized self-checking bench for dot8_result_gather.
// Revision : 1.0
// ============================================================================
module tb_dot8_result_gather;

  localparam int NL = 1;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [NL-1:0] in_tmask;
  logic [43:0]   in_uuid;
  logic [1:0]    in_wid;
  logic [29:0]   in_PC;
  logic          in_wb;
  logic [4:0]    in_rd;
  logic [1:0]    in_pid;
  logic          in_sop;
  logic          in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic [NT-1:0] out_tmask;
  logic [43:0]   out_uuid;
  logic [1:0]    out_wid;
  logic [29:0]   out_PC;
  logic          out_wb;
  logic [4:0]    out_rd;
  logic          err_proto;

  always #5 clk = ~clk;

  dot8_result_gather dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tmask(in_tmask),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_wb(in_wb), .in_rd(in_rd),
    .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tmask(out_tmask),
    .out_uuid(out_uuid), .out_wid(out_wid), .out_PC(out_PC), .out_wb(out_wb), .out_rd(out_rd),
    .err_proto(err_proto)
  );

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tmask;
    logic [43:0]  uuid;
    logic [1:0]   wid;
    logic [29:0]  pc;
    logic         wb;
    logic [4:0]   rd;
  } pkt_t;

  pkt_t        exp_q[$];
  pkt_t        m_cur;
  bit          m_open;
  logic        m_err;
  int          n_chk, n_fail, n_out, n_stall;
  logic [43:0] g_uuid;
  logic [29:0] g_pc;
  logic        g_wb;
  logic [4:0]  g_rd;
  bit          rnd_rdy;
  bit          hold;
  logic [127:0] held_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level reference: a packet opens at sop and is emitted at eop.
  task automatic model_beat(input int pid, input bit sop, input bit eop,
                            input logic [31:0] d, input logic t, input logic [1:0] wid);
    if (sop) begin
      if (m_open) m_err = 1'b1;
      m_cur.data  = '0;
      m_cur.tmask = '0;
      m_cur.uuid  = g_uuid;
      m_cur.wid   = wid;
      m_cur.pc    = g_pc;
      m_cur.wb    = g_wb;
      m_cur.rd    = g_rd;
      m_open      = 1'b1;
    end else if (!m_open) begin
      m_err = 1'b1;
      return;
    end else if (wid != m_cur.wid || g_uuid != m_cur.uuid) begin
      m_err = 1'b1;
    end
    m_cur.data[pid*32 +: 32] = d;
    m_cur.tmask[pid]         = t;
    if (eop) begin
      exp_q.push_back(m_cur);
      m_open = 1'b0;
    end
  endtask

  task automatic send(input int pid, input bit sop, input bit eop,
                      input logic [31:0] d, input logic t, input logic [1:0] wid);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_pid   = pid[1:0];
    in_sop   = sop;
    in_eop   = eop;
    in_data  = d;
    in_tmask = t;
    in_wid   = wid;
    in_uuid  = g_uuid;
    in_PC    = g_pc;
    in_wb    = g_wb;
    in_rd    = g_rd;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) n_stall++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 128'(acc), 128'd1);
    else model_beat(pid, sop, eop, d, t, wid);
  endtask

  task automatic send_packet(input int len, input logic [1:0] wid);
    for (int p = 0; p < len; p++)
      send(p, p == 0, p == len - 1, $urandom(), 1'($urandom_range(0, 1)), wid);
  endtask

  // Output scoreboard plus hold-stability check while backpressured.
  always @(negedge clk) begin
    if (reset) begin
      if (hold) begin
        check("hold_valid", 128'(out_valid), 128'd1);
        check("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        check("expected_avail", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          pkt_t p;
          p = exp_q.pop_front();
          check("out_data", out_data, p.data);
          check("out_tmask", 128'(out_tmask), 128'(p.tmask));
          check("out_uuid", 128'(out_uuid), 128'(p.uuid));
          check("out_wid", 128'(out_wid), 128'(p.wid));
          check("out_PC", 128'(out_PC), 128'(p.pc));
          check("out_wb", 128'(out_wb), 128'(p.wb));
          check("out_rd", 128'(out_rd), 128'(p.rd));
        end
        n_out++;
      end
      hold      = out_valid && !out_ready;
      held_data = out_data;
    end else begin
      hold = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [31:0] t1 [4];
    int snap_out, snap_stall, len;
    t1 = '{32'h10, 32'hFFFF_FFF0, 32'h7E02, 32'h0};
    n_chk = 0; n_fail = 0; n_out = 0; n_stall = 0;
    m_open = 1'b0; m_err = 1'b0; rnd_rdy = 1'b0; hold = 1'b0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tmask = '0; in_uuid = '0; in_wid = '0; in_PC = '0;
    in_wb = 1'b0; in_rd = '0; in_pid = '0; in_sop = 1'b0; in_eop = 1'b0;
    g_uuid = 44'h123; g_pc = 30'h100; g_wb = 1'b1; g_rd = 5'd7;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_tmask", 128'(out_tmask), 128'd0);
    check("rst_out_meta", {out_uuid, out_wid, out_PC, out_wb, out_rd}, 128'd0);
    check("rst_err", 128'(err_proto), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Basic 4-chunk packet; output one cycle after eop
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) send(p, p == 0, p == 3, t1[p], 1'b1, 2'd2);
    check("t1_valid", 128'(out_valid), 128'd1);
    check("t1_data", out_data, 128'h0000_0000_0000_7E02_FFFF_FFF0_0000_0010);
    check("t1_tmask", 128'(out_tmask), 128'hF);
    check("t1_wid", 128'(out_wid), 128'd2);
    check("t1_rd", 128'(out_rd), 128'd7);
    check("t1_err", 128'(err_proto), 128'd0);
    @(posedge clk);
    #1;
    check("t1_drained", 128'(out_valid), 128'd0);

    // Backpressure hold, then fire concurrent with a short sop&eop packet
    out_ready = 1'b0;
    g_uuid = 44'h456;
    send_packet(4, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_in_ready_low", 128'(in_ready), 128'd0);
      check("t2_valid_held", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    out_ready  = 1'b1;
    snap_stall = n_stall;
    g_uuid = 44'h789;
    send(0, 1'b1, 1'b1, 32'h55, 1'b1, 2'd3);
    check("t2_sop_on_fire", 128'(n_stall - snap_stall), 128'd0);
    check("t3_data", out_data, 128'h55);
    check("t3_tmask", 128'(out_tmask), 128'h1);
    @(posedge clk);
    #1;

    // Stray non-sop while idle, then restart inside COLLECT
    send(1, 1'b0, 1'b0, 32'hDEAD, 1'b1, 2'd0);
    check("t4_no_output", 128'(out_valid), 128'd0);
    check("t4_err", 128'(err_proto), 128'd1);
    g_uuid = 44'hABC;
    send(0, 1'b1, 1'b0, 32'h1111, 1'b1, 2'd1);
    send(0, 1'b1, 1'b0, 32'h2222, 1'b1, 2'd1);
    send(1, 1'b0, 1'b0, 32'h3333, 1'b1, 2'd1);
    send(2, 1'b0, 1'b0, 32'h4444, 1'b0, 2'd1);
    send(3, 1'b0, 1'b1, 32'h5555, 1'b1, 2'd1);
    check("t4_data", out_data, 128'h0000_5555_0000_4444_0000_3333_0000_2222);
    check("t4_err_sticky", 128'(err_proto), 128'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a packet
    send(0, 1'b1, 1'b0, 32'hAAAA, 1'b1, 2'd0);
    send(1, 1'b0, 1'b0, 32'hBBBB, 1'b1, 2'd0);
    #2;
    reset = 1'b0;
    #1;
    check("t5_valid_async", 128'(out_valid), 128'd0);
    check("t5_err_async", 128'(err_proto), 128'd0);
    check("t5_in_ready", 128'(in_ready), 128'd0);
    m_open = 1'b0; m_err = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    snap_out = n_out;
    send_packet(4, 2'd2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_one_output", 128'(n_out - snap_out), 128'd1);
    check("t5_err_clear", 128'(err_proto), 128'd0);

    // Eight back-to-back packets at full rate
    snap_out = n_out;
    snap_stall = n_stall;
    for (int k = 0; k < 8; k++) begin
      g_uuid = 44'({$urandom(), $urandom()});
      g_pc   = 30'($urandom());
      g_rd   = 5'($urandom());
      g_wb   = 1'($urandom());
      send_packet(4, 2'($urandom()));
    end
    repeat (3) @(posedge clk);
    #1;
    check("t6_outputs", 128'(n_out - snap_out), 128'd8);
    check("t6_no_stall", 128'(n_stall - snap_stall), 128'd0);

    // Random lengths, random backpressure, occasional framing faults
    rnd_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [1:0] w;
      g_uuid = 44'({$urandom(), $urandom()});
      g_pc   = 30'($urandom());
      g_rd   = 5'($urandom());
      g_wb   = 1'($urandom());
      w      = 2'($urandom());
      len    = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) send(1, 1'b0, 1'b0, $urandom(), 1'b1, w);
      for (int p = 0; p < len; p++) begin
        logic [1:0] bw;
        bw = (p != 0 && $urandom_range(0, 9) == 0) ? w + 2'd1 : w;
        send(p, p == 0, p == len - 1, $urandom(), 1'($urandom_range(0, 1)), bw);
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    check("final_err", 128'(err_proto), 128'(m_err));
    check("final_idle", 128'(out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot8_result_gather.md
Name: dot8_result_gather

Overview:
- Sits directly downstream of the dot8 ALU PE serializer, between its lane-serialized result stream and the commit/writeback path.
- Each input beat carries NUM_LANES int32 dot8 results for one pid chunk of a warp instruction.
- The block reassembles the sop..eop chunks into one full NUM_THREADS-wide writeback, with registered valid/ready on both sides.
- It also flags framing violations in the chunk stream.

Parameters:
- NUM_LANES, 1, lanes per input beat (PE count of upstream serializer).
- NUM_THREADS, 4, threads per warp; must be a multiple of NUM_LANES.
- XLEN, 32, result word width.
- UUID_WIDTH, 44, instruction uuid width.
- NW_WIDTH, 2, warp id width.
- PC_BITS, 30, PC width.
- NUM_REGS_BITS, 5, rd width.
- PID_WIDTH, max(1, clog2(NUM_THREADS/NUM_LANES)), derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  NUM_LANES*XLEN  lane results, lane 0 in LSBs.
- in_tmask  in  NUM_LANES  lane active mask.
- in_uuid / in_wid / in_PC / in_wb / in_rd  in  UUID_WIDTH/NW_WIDTH/PC_BITS/1/NUM_REGS_BITS  instruction metadata.
- in_pid  in  PID_WIDTH  chunk index.
- in_sop, in_eop  in  1  first / last chunk of the instruction.
- out_valid  out  1  assembled writeback valid.
- out_ready  in  1  downstream accept.
- out_data  out  NUM_THREADS*XLEN  assembled results, thread t at [t*XLEN +: XLEN].
- out_tmask  out  NUM_THREADS  assembled mask.
- out_uuid / out_wid / out_PC / out_wb / out_rd  out  as inputs  metadata captured at sop.
- err_proto  out  1  sticky framing-error flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; out_valid=0, out_data=0, out_tmask=0, all out metadata=0, err_proto=0. in_ready is 0 during reset. Reset mid-packet discards the partial packet.
- FSM states: IDLE, COLLECT, FULL.
- in_ready is 1 in IDLE and COLLECT. In FULL, in_ready = out_ready, so the next sop may be accepted in the same cycle the output fires.
- Chunk write: an accepted beat writes in_data/in_tmask to thread slots [in_pid*NUM_LANES +: NUM_LANES].
- On an accepted sop beat:
  - all other slots' tmask and data are cleared to 0;
  - metadata is latched from this beat.
- IDLE transitions:
  - accepted sop&eop -> FULL;
  - accepted sop&!eop -> COLLECT;
  - accepted beat without sop -> dropped, err_proto=1, stay IDLE.
- COLLECT transitions:
  - accepted !sop&eop -> FULL;
  - accepted !sop&!eop -> write, stay COLLECT;
  - accepted sop -> partial packet discarded, err_proto=1, restart with this beat (-> FULL if eop, else COLLECT);
  - in_wid or in_uuid differing from the latched value on a non-sop beat -> err_proto=1; the beat is still written.
- FULL:
  - out_valid=1; outputs are held stable until out_valid&out_ready.
  - On fire with no simultaneous accepted beat -> IDLE, out_valid=0 next cycle.
  - On fire with a simultaneous accepted sop -> COLLECT, or FULL if that beat also has eop. The new packet overwrites the buffer after the old one is consumed, in the same edge.
  - On fire with a simultaneous accepted non-sop beat -> err_proto=1, beat dropped, -> IDLE.
- Latency: out_valid rises the cycle after the eop beat is accepted. Throughput is one instruction per (chunks) cycles with no bubble when out_ready=1.
- Outputs are driven directly from registers, with no combinational input-to-output path except in_ready<-out_ready in FULL.
- A pid out of range (>= NUM_THREADS/NUM_LANES) cannot occur by construction; the behaviour is don't-care, asserted in simulation.
- err_proto clears only on reset.

Test Plan:
- NUM_LANES=1, NUM_THREADS=4; beats pid0..3 with data 0x10,0xFFFFFFF0,0x7E02,0x0 (sop on pid0, eop on pid3), tmask=1, wid=2, rd=7 -> one output cycle after the eop beat: out_data={0x0,0x7E02,0xFFFFFFF0,0x10}, out_tmask=4'b1111, out_wid=2, out_rd=7, err_proto=0.
- Same packet with out_ready=0 for 5 cycles after FULL -> out_valid and out_data held stable; in_ready=0. When out_ready rises the output fires, and a sop beat presented in that same cycle is accepted (in_ready=1).
- Packet of only pid0 (sop&eop, data 0x55) following a full packet -> out_data={0,0,0,0x55}, out_tmask=4'b0001 (stale slots cleared).
- Non-sop beat while IDLE -> beat dropped, no output, err_proto=1 and stays 1. Then sop at pid0, a second sop at pid0 in COLLECT, then pid1..3 with eop -> output reflects the second packet only.
- Assert reset low while in COLLECT after 2 beats -> out_valid=0, err_proto=0 immediately (async). After release, a full 4-beat packet produces exactly one correct output.
- Back-to-back packets with out_ready=1 constantly, 8 packets -> 8 outputs, no dropped beats, in_ready never low outside reset.
